// File: rtl/draw_scheduler.sv
// draw_scheduler: per-frame sequencer and pixel-port arbiter for the view
// layer's draw FSMs. Each frame_tick walks the unmasked clients in ascending
// index order: it pulses the client's enable, forwards that client's pixel
// writes to the single VGA port, and waits for the client's done pulse. A
// watchdog moves on from a client that never finishes.
module draw_scheduler #(
  parameter int          NUM_CLIENTS = 4,
  parameter int          IDW         = 2,
  parameter logic [19:0] TIMEOUT     = 20'd76800
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      frame_tick,
  input  logic [NUM_CLIENTS-1:0]    client_mask,
  input  logic [NUM_CLIENTS-1:0]    client_done,
  input  logic [9*NUM_CLIENTS-1:0]  client_x,
  input  logic [8*NUM_CLIENTS-1:0]  client_y,
  input  logic [12*NUM_CLIENTS-1:0] client_color,
  input  logic [NUM_CLIENTS-1:0]    client_we,
  input  logic                      clear_flags,
  output logic [NUM_CLIENTS-1:0]    client_enable,
  output logic [8:0]                vga_x,
  output logic [7:0]                vga_y,
  output logic [11:0]               vga_color,
  output logic                      vga_write,
  output logic [IDW-1:0]            active_id,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      overrun,
  output logic                      timeout_flag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_START,
    S_WAIT,
    S_NEXT,
    S_FRAME_DONE
  } state_t;

  localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_CLIENTS - 1);

  state_t                 state, state_next;
  logic [IDW-1:0]         idx, idx_next;
  logic [NUM_CLIENTS-1:0] mask_r, mask_next;
  logic [19:0]            wd_cnt, wd_next;
  logic                   set_timeout;
  logic                   forwarding;

  // Per-client views of the packed pixel buses.
  logic [8:0]  x_arr     [NUM_CLIENTS];
  logic [7:0]  y_arr     [NUM_CLIENTS];
  logic [11:0] color_arr [NUM_CLIENTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
      assign x_arr[gi]     = client_x[9*gi +: 9];
      assign y_arr[gi]     = client_y[8*gi +: 8];
      assign color_arr[gi] = client_color[12*gi +: 12];
    end
  endgenerate

  // State, client index, latched frame mask and watchdog counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      idx    <= '0;
      mask_r <= '0;
      wd_cnt <= '0;
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      mask_r <= mask_next;
      wd_cnt <= wd_next;
    end
  end

  // Next-state logic plus the Moore enable / frame_done pulses.
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    mask_next     = mask_r;
    wd_next       = wd_cnt;
    set_timeout   = 1'b0;
    client_enable = '0;
    frame_done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_tick) begin
          mask_next  = client_mask;
          idx_next   = '0;
          state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        // Masked clients are skipped at one cycle each.
        if (mask_r[idx]) begin
          state_next = S_START;
        end else if (idx == LAST_IDX) begin
          state_next = S_FRAME_DONE;
        end else begin
          idx_next = idx + IDW'(1);
        end
      end
      S_START: begin
        client_enable[idx] = 1'b1;
        wd_next            = '0;
        state_next         = S_WAIT;
      end
      S_WAIT: begin
        wd_next = wd_cnt + 20'd1;
        // A done arriving on the timeout cycle wins: the client finished.
        if (client_done[idx]) begin
          state_next = S_NEXT;
        end else if (wd_cnt == TIMEOUT - 20'd1) begin
          set_timeout = 1'b1;
          state_next  = S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx == LAST_IDX) begin
          state_next = S_FRAME_DONE;
        end else begin
          idx_next   = idx + IDW'(1);
          state_next = S_SCAN;
        end
      end
      S_FRAME_DONE: begin
        frame_done = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Sticky status flags; clear_flags beats a set in the same cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overrun      <= 1'b0;
      timeout_flag <= 1'b0;
    end else if (clear_flags) begin
      overrun      <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      if (set_timeout) begin
        timeout_flag <= 1'b1;
      end
      if (frame_tick && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

  // Only the client being served owns the VGA port; otherwise it is quiet.
  always_comb begin
    forwarding = (state == S_START) || (state == S_WAIT);
    vga_x      = '0;
    vga_y      = '0;
    vga_color  = '0;
    vga_write  = 1'b0;
    if (forwarding) begin
      vga_x     = x_arr[idx];
      vga_y     = y_arr[idx];
      vga_color = color_arr[idx];
      vga_write = client_we[idx];
    end
  end

  assign busy      = (state != S_IDLE);
  assign active_id = idx;

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: a client model answers enables with done pulses,
// a scoreboard checks the order of enables and frame_done pulses, and
// table vectors plus hand sequences cover masking, timeout, overrun and reset.
module tb_draw_scheduler;
  localparam int N  = 4;
  localparam int TO = 16;
  localparam int DONE_DELAY = 10;

  logic            clock = 1'b0;
  logic            resetn = 1'b1;
  logic            frame_tick = 1'b0;
  logic            clear_flags = 1'b0;
  logic [N-1:0]    client_mask = '0;
  logic [N-1:0]    client_done;
  logic [N-1:0]    model_done = '0;
  logic [N-1:0]    spur_done = '0;
  logic [N-1:0]    client_we = '1;
  logic [9*N-1:0]  client_x;
  logic [8*N-1:0]  client_y;
  logic [12*N-1:0] client_color;
  logic [N-1:0]    client_enable;
  logic [8:0]      vga_x;
  logic [7:0]      vga_y;
  logic [11:0]     vga_color;
  logic            vga_write;
  logic [1:0]      active_id;
  logic            busy;
  logic            frame_done;
  logic            overrun;
  logic            timeout_flag;

  assign client_done = model_done | spur_done;

  draw_scheduler #(.NUM_CLIENTS(N), .IDW(2), .TIMEOUT(20'd16)) dut (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick),
    .client_mask(client_mask), .client_done(client_done),
    .client_x(client_x), .client_y(client_y), .client_color(client_color),
    .client_we(client_we), .clear_flags(clear_flags),
    .client_enable(client_enable), .vga_x(vga_x), .vga_y(vga_y),
    .vga_color(vga_color), .vga_write(vga_write), .active_id(active_id),
    .busy(busy), .frame_done(frame_done), .overrun(overrun),
    .timeout_flag(timeout_flag)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int cyc = 0;
  int fd_cnt = 0;
  int en_cyc[N];
  int cnt[N];
  logic [N-1:0] hang = '0;
  logic [N-1:0] cur_mask = '0;

  function automatic int ex_x(int i);     return (37 * i + 11) % 512;   endfunction
  function automatic int ex_y(int i);     return (13 * i + 7) % 256;    endfunction
  function automatic int ex_color(int i); return (291 * i + 5) % 4096;  endfunction

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Client model: done pulse DONE_DELAY cycles after enable, unless hung.
  always @(negedge clock) begin
    model_done = '0;
    for (int i = 0; i < N; i++) begin
      if (!resetn) cnt[i] = 0;
      else if (client_enable[i]) cnt[i] = hang[i] ? 0 : DONE_DELAY;
      else if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) model_done[i] = 1'b1;
      end
    end
  end

  // Monitor: scoreboard pops on each enable / frame_done; port-ownership check.
  always @(negedge clock) begin
    if (resetn) begin
      int id;
      int exp;
      cyc++;
      if (client_enable != '0) begin
        chk("enable_onehot", $countones(client_enable), 1);
        id = 0;
        for (int i = 0; i < N; i++) if (client_enable[i]) id = i;
        en_cyc[id] = cyc;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk("sb_enable_id", id, exp);
        chk("we_during_start", int'(vga_write), 1);
      end
      if (frame_done) begin
        fd_cnt++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk("sb_frame_done", 8, exp);
      end
      if (vga_write) begin
        chk("write_from_unmasked", int'(cur_mask[active_id]), 1);
        chk("fwd_x", int'(vga_x), ex_x(int'(active_id)));
        chk("fwd_y", int'(vga_y), ex_y(int'(active_id)));
        chk("fwd_color", int'(vga_color), ex_color(int'(active_id)));
      end
    end
  end

  task automatic start_frame(input logic [N-1:0] m);
    @(negedge clock);
    for (int i = 0; i < N; i++) if (m[i]) exp_q.push_back(i);
    exp_q.push_back(8);
    cur_mask    = m;
    client_mask = m;
    frame_tick  = 1'b1;
    @(negedge clock);
    frame_tick  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (busy) chk({name, "_idle_timeout"}, 1, 0);
    chk({name, "_sb_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_enable(input int k, input string name);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!client_enable[k] && n < 200);
    if (!client_enable[k]) chk({name, "_enable_timeout"}, 0, 1);
  endtask

  task automatic pulse_clear();
    @(negedge clock);
    clear_flags = 1'b1;
    @(negedge clock);
    clear_flags = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] mask;
    logic [N-1:0] hang;
    int           exp_to;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int fd0;
    int n;
    vecs[0] = '{4'b1111, 4'b0000, 0};
    vecs[1] = '{4'b0101, 4'b0000, 0};
    vecs[2] = '{4'b0000, 4'b0000, 0};
    vecs[3] = '{4'b1000, 4'b0000, 0};
    vecs[4] = '{4'b0110, 4'b0100, 1};
    vecs[5] = '{4'b0001, 4'b0001, 1};
    for (int i = 0; i < N; i++) begin
      client_x[9*i +: 9]       = 9'(ex_x(i));
      client_y[8*i +: 8]       = 8'(ex_y(i));
      client_color[12*i +: 12] = 12'(ex_color(i));
    end

    // Reset state.
    #1 resetn = 1'b0;
    #11;
    chk("rst_busy", int'(busy), 0);
    chk("rst_enable", int'(client_enable), 0);
    chk("rst_vga_write", int'(vga_write), 0);
    chk("rst_vga_x", int'(vga_x), 0);
    chk("rst_active_id", int'(active_id), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_timeout", int'(timeout_flag), 0);
    @(negedge clock);
    resetn = 1'b1;

    // Table-driven frames.
    for (int v = 0; v < 6; v++) begin
      hang = vecs[v].hang;
      fd0  = fd_cnt;
      start_frame(vecs[v].mask);
      wait_idle($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_frame_done_cnt", v), fd_cnt - fd0, 1);
      chk($sformatf("vec%0d_timeout_flag", v), int'(timeout_flag), vecs[v].exp_to);
      chk($sformatf("vec%0d_overrun", v), int'(overrun), 0);
      pulse_clear();
      chk($sformatf("vec%0d_flag_cleared", v), int'(timeout_flag), 0);
    end
    hang = '0;

    // Enable spacing for done-driven clients and the watchdog on client 1.
    hang = 4'b0010;
    start_frame(4'b1111);
    wait_idle("timeout");
    chk("done_gap_0_1", en_cyc[1] - en_cyc[0], DONE_DELAY + 3);
    chk("timeout_gap_1_2", en_cyc[2] - en_cyc[1], TO + 3);
    chk("timeout_flag_set", int'(timeout_flag), 1);
    repeat (5) @(negedge clock);
    chk("timeout_flag_sticky", int'(timeout_flag), 1);
    pulse_clear();
    chk("timeout_flag_clear", int'(timeout_flag), 0);
    hang = '0;

    // frame_tick while busy: clear wins first, then overrun sets; pass unchanged.
    fd0 = fd_cnt;
    start_frame(4'b1111);
    wait_enable(0, "overrun");
    @(negedge clock);
    frame_tick = 1'b1; clear_flags = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0; clear_flags = 1'b0;
    chk("clear_priority", int'(overrun), 0);
    client_mask = 4'b0001;
    frame_tick  = 1'b1;
    @(negedge clock);
    frame_tick  = 1'b0;
    chk("overrun_set", int'(overrun), 1);
    wait_idle("overrun");
    repeat (20) @(negedge clock);
    chk("overrun_no_second_pass", fd_cnt - fd0, 1);
    chk("overrun_idle_after", int'(busy), 0);
    pulse_clear();
    chk("overrun_clear", int'(overrun), 0);

    // frame_tick in the FRAME_DONE cycle is also dropped as an overrun.
    fd0 = fd_cnt;
    start_frame(4'b0000);
    n = 0;
    while (!frame_done && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!frame_done) chk("fd_overrun_wait", 0, 1);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    chk("fd_overrun_set", int'(overrun), 1);
    chk("fd_overrun_not_busy", int'(busy), 0);
    repeat (10) @(negedge clock);
    chk("fd_overrun_one_pass", fd_cnt - fd0, 1);
    pulse_clear();

    // Spurious done from a non-active client is ignored.
    start_frame(4'b1111);
    wait_enable(0, "spur");
    repeat (3) @(negedge clock);
    spur_done = 4'b1000;
    @(negedge clock);
    spur_done = '0;
    wait_idle("spur");
    chk("spur_done_gap", en_cyc[1] - en_cyc[0], DONE_DELAY + 3);

    // Reset in the middle of WAIT abandons the pass.
    start_frame(4'b1111);
    wait_enable(0, "midrst");
    repeat (3) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_vga_write", int'(vga_write), 0);
    chk("midrst_vga_color", int'(vga_color), 0);
    chk("midrst_active_id", int'(active_id), 0);
    exp_q.delete();
    fd0 = fd_cnt;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    chk("midrst_no_frame_done", fd_cnt - fd0, 0);
    start_frame(4'b1111);
    wait_idle("after_rst");
    chk("after_rst_frame_done", fd_cnt - fd0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global safety bound on simulation length.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
